// File: rtl/fa_pipe_adder.sv
// rtl/fa_pipe_adder.sv - pipelined chunked ripple-carry adder/subtractor on a valid/ready stream
module fa_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int STAGES = WIDTH / CHUNK;

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("fa_pipe_adder: WIDTH must be a multiple of CHUNK");
    end

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic              ovf_q;

    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] c_src;
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  s_d   [STAGES];
    logic [CHUNK:0]    chunk [STAGES];
    logic              ovf_d;
    logic              adv;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = ~v_q[STAGES-1] | out_ready;
    assign in_ready = adv;

    always_comb begin
        // b is stored already inverted for subtract, so the sub flag only
        // needs to exist at the input to pick b_eff and the initial carry.
        a_src[0] = in_a;
        b_src[0] = in_sub ? ~in_b : in_b;
        c_src[0] = in_sub | in_cin;
        v_d[0]   = in_valid;
        s_d[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            c_src[k] = c_q[k-1];
            v_d[k]   = v_q[k-1];
            s_d[k]   = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            chunk[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                     + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, c_src[k]};
            s_d[k][k*CHUNK +: CHUNK] = chunk[k][CHUNK-1:0];
            c_d[k] = chunk[k][CHUNK];
        end
        ovf_d = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1])
              & (s_d[STAGES-1][WIDTH-1] != a_src[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q   <= v_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = s_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_fa_pipe_adder.sv
// tb/tb_fa_pipe_adder.sv - randomized scoreboard bench for fa_pipe_adder
module tb_fa_pipe_adder;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int STAGES = WIDTH / CHUNK;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              in_cin;
    logic              in_sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_sum;
    logic              out_cout;
    logic              out_ovf;

    always #5 clk = ~clk;

    fa_pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    int          total = 0;
    int          bad   = 0;
    int          n_acc = 0;
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    logic        prev_stall = 1'b0;
    logic [17:0] prev_out   = '0;
    logic        last_in_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Golden result {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] golden(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sub);
        int   ua = int'(a);
        int   ub = int'(b);
        int   sa = int'($signed(a));
        int   sb = int'($signed(b));
        int   r;
        int   sr;
        logic cout;
        logic ovf;
        if (sub) begin
            r    = ua - ub;
            sr   = sa - sb;
            cout = (ua >= ub);
        end else begin
            r    = ua + ub + int'(cin);
            sr   = sa + sb + int'(cin);
            cout = (r > 65535);
        end
        ovf = (sr > 32767) || (sr < -32768);
        return {ovf, cout, r[15:0]};
    endfunction

    task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        out_ready = ordy;
        #1;
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'({out_ovf, out_cout, out_sum}), 32'(prev_out));
        end
        if (out_valid && out_ready) begin
            chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                chk("beat", 32'({out_ovf, out_cout, out_sum}), 32'(exp_q.pop_front()));
            got_q.push_back({out_ovf, out_cout, out_sum});
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(golden(a, b, cin, sub));
            n_acc++;
        end
        last_in_ready = in_ready;
        prev_stall    = out_valid & ~out_ready;
        prev_out      = {out_ovf, out_cout, out_sum};
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordy);
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub,
                            input logic [15:0] es, input logic ec, input logic eo);
        int lat = 0;
        int n0  = got_q.size();
        step(1'b1, a, b, cin, sub, 1'b1);
        while (got_q.size() == n0 && lat < 20) begin
            idle(1'b1);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(STAGES));
        chk({tag, "_count"}, 32'(got_q.size()), 32'(n0 + 1));
        if (got_q.size() > n0)
            chk({tag, "_result"}, 32'(got_q[got_q.size()-1]), 32'({eo, ec, es}));
    endtask

    initial begin
        int n0;
        int cyc;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_cout", 32'(out_cout), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        directed("t1_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("t2_ripple", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        directed("sub_zero", 16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Back-to-back add then subtract; cin must be ignored on the subtract.
        n0 = got_q.size();
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
        cyc = 0;
        while (got_q.size() < n0 + 2 && cyc < 20) begin idle(1'b1); cyc++; end
        chk("t3_count", 32'(got_q.size()), 32'(n0 + 2));
        if (got_q.size() >= n0 + 2) begin
            chk("t3_add_ovf", 32'(got_q[n0]), 32'({1'b1, 1'b0, 16'h8000}));
            chk("t3_sub", 32'(got_q[n0+1]), 32'({1'b0, 1'b0, 16'hFFFE}));
        end

        // Random stream with random back-pressure.
        n_acc = 0;
        cyc = 0;
        while (n_acc < 200 && cyc < 5000) begin
            step(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom), ($urandom % 3) != 0);
            cyc++;
        end
        chk("t4_accepted", 32'(n_acc), 32'd200);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin idle(1'($urandom)); cyc++; end
        chk("t4_drained", 32'(exp_q.size()), 32'd0);

        // Reset with beats in flight.
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_out_sum", 32'(out_sum), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        n0 = got_q.size();
        repeat (10) idle(1'b1);
        chk("t5_no_ghost", 32'(got_q.size()), 32'(n0));

        // Full pipe under back-pressure, then drain.
        n_acc = 0;
        repeat (10) step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        chk("t6_held", 32'(n_acc), 32'(STAGES));
        chk("t6_in_ready", 32'(last_in_ready), 32'd0);
        n0 = got_q.size();
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin idle(1'b1); cyc++; end
        chk("t6_drain_count", 32'(got_q.size()), 32'(n0 + STAGES));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
